// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
//   Word-level SPI master. A word accepted on the tx valid/ready port is
//   shifted out MSB first on spi_mosi. At the same time, a word is shifted in
//   from spi_miso. The received word is returned on a one-cycle rx_valid
//   strobe. SCLK polarity and phase are set by CPOL/CPHA.
//
//   Optional feature (compile-time macro SPI_MASTER_BURST_EN):
//     When defined, a word latched with tx_last==0 keeps chip select asserted.
//     The FSM then parks in WAIT, so the next word continues the same frame
//     without a SETUP phase.
//     When undefined, tx_last is ignored and every word gets its own frame.
//
// Parameters
//   DATA_W   bits per word (2..32)
//   CLK_DIV  clk cycles per SCLK half-period (>= 1)
//   CPOL     SCLK idle level
//   CPHA     0: sample on leading edge, 1: sample on trailing edge
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   tx_valid/ready    request handshake; tx_data/tx_last latched on handshake
//   rx_valid/rx_data  received-word strobe; rx_data holds until next strobe
//   busy              high whenever the FSM is not in IDLE
//   spi_sclk/mosi/cs_n/miso   SPI master-side pins (miso used unsynchronised)
// -----------------------------------------------------------------------------
module spi_master_core #(
   parameter int   DATA_W  = 8,
   parameter int   CLK_DIV = 4,
   parameter logic CPOL    = 1'b0,
   parameter logic CPHA    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs_n
);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("spi_master_core: CLK_DIV must be >= 1");
   end
   if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
      $error("spi_master_core: DATA_W must be in 2..32");
   end

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_W);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
`ifdef SPI_MASTER_BURST_EN
      , WAIT
`endif
   } state_t;

   state_t              state, state_nx;
   logic [DIV_W-1:0]    div_cnt;
   logic [EDGE_W-1:0]   edge_cnt;
   logic [DATA_W-1:0]   sreg;
   logic [DATA_W-1:0]   sreg_shift;
   logic [DATA_W-1:0]   word_done;
   logic                wrap;
   logic                tick;
   logic                last_edge;
   logic                leading;
   logic                hs;
   logic                rx_fire;

`ifdef SPI_MASTER_BURST_EN
   logic                last_q;
`else
   logic                tx_last_unused;
   assign tx_last_unused = tx_last;
`endif

   assign wrap       = (div_cnt == DIV_LAST);
   assign tick       = (state == XFER) && wrap;
   assign last_edge  = (edge_cnt == EDGE_LAST);
   assign leading    = ~edge_cnt[0];
   assign sreg_shift = {sreg[DATA_W-2:0], spi_miso};
   // With CPHA=1 the final sample lands on the final toggle itself, so a word
   // completing straight out of XFER must include that last MISO bit.
   assign word_done  = (CPHA && state == XFER) ? sreg_shift : sreg;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, handshake and status outputs
   always_comb begin
      state_nx = state;
      tx_ready = 1'b0;
      busy     = 1'b1;
      hs       = 1'b0;
      rx_fire  = 1'b0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            tx_ready = ~rst;
            hs       = tx_valid & ~rst;
            if (hs) state_nx = SETUP;
         end
         SETUP: begin
            if (wrap) state_nx = XFER;
         end
         XFER: begin
            if (tick && last_edge) begin
`ifdef SPI_MASTER_BURST_EN
               if (last_q) begin
                  state_nx = HOLD;
               end else begin
                  state_nx = WAIT;
                  rx_fire  = 1'b1;
               end
`else
               state_nx = HOLD;
`endif
            end
         end
         HOLD: begin
            if (wrap) begin
               state_nx = IDLE;
               rx_fire  = 1'b1;
            end
         end
`ifdef SPI_MASTER_BURST_EN
         WAIT: begin
            tx_ready = ~rst;
            hs       = tx_valid & ~rst;
            if (hs) state_nx = XFER;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // Divider, edge counter, pins and received-word output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         edge_cnt <= '0;
         spi_sclk <= CPOL;
         spi_mosi <= 1'b0;
         spi_cs_n <= 1'b1;
         rx_valid <= 1'b0;
         rx_data  <= '0;
`ifdef SPI_MASTER_BURST_EN
         last_q   <= 1'b1;
`endif
      end else begin
         rx_valid <= rx_fire;
         if (rx_fire) rx_data <= word_done;
         // Registered so chip select never glitches on a state decode.
         spi_cs_n <= (state_nx == IDLE);

         if (state == SETUP || state == XFER || state == HOLD) begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
         end

         if (hs) begin
            edge_cnt <= '0;
            // CPHA=0 needs the MSB on the wire before the first leading edge.
            if (!CPHA) spi_mosi <= tx_data[DATA_W-1];
`ifdef SPI_MASTER_BURST_EN
            last_q <= tx_last;
`endif
         end

         if (tick) begin
            spi_sclk <= ~spi_sclk;
            edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
            if (!CPHA) begin
               // sreg already shifted on the leading edge, so its MSB is the
               // next bit; the final trailing edge leaves MOSI alone.
               if (!leading && !last_edge) spi_mosi <= sreg[DATA_W-1];
            end else if (leading) begin
               spi_mosi <= sreg[DATA_W-1];
            end
         end
      end
   end

   // Shift register: one register serves both directions. TX bits leave the
   // top while RX bits enter the bottom on the sampling edge.
   always_ff @(posedge clk) begin
      if (hs) begin
         sreg <= tx_data;
      end else if (tick && (leading ^ CPHA)) begin
         sreg <= sreg_shift;
      end
   end

endmodule

// File: tb/tb_spi_master_core.sv
module tb_spi_master_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- u0: mode 0, DATA_W=8, CLK_DIV=4 ----------------
   logic       rst0 = 1'b0, tv0 = 1'b0, tl0 = 1'b1, miso0 = 1'b0;
   logic [7:0] td0 = 8'h00;
   logic       rdy0, rv0, busy0, sclk0, mosi0, cs0;
   logic [7:0] rd0;

   spi_master_core #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) u0 (
      .clk(clk), .rst(rst0), .tx_valid(tv0), .tx_ready(rdy0), .tx_data(td0),
      .tx_last(tl0), .rx_valid(rv0), .rx_data(rd0), .busy(busy0),
      .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs_n(cs0));

   // ---------------- u3: mode 3, DATA_W=8, CLK_DIV=4 ----------------
   logic       rst3 = 1'b0, tv3 = 1'b0, tl3 = 1'b1, miso3 = 1'b0;
   logic [7:0] td3 = 8'h00;
   logic       rdy3, rv3, busy3, sclk3, mosi3, cs3;
   logic [7:0] rd3;

   spi_master_core #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1)) u3 (
      .clk(clk), .rst(rst3), .tx_valid(tv3), .tx_ready(rdy3), .tx_data(td3),
      .tx_last(tl3), .rx_valid(rv3), .rx_data(rd3), .busy(busy3),
      .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_miso(miso3), .spi_cs_n(cs3));

   // ---------------- u16: mode 0, DATA_W=16, CLK_DIV=1 ----------------
   logic        rst16 = 1'b0, tv16 = 1'b0, tl16 = 1'b1, miso16 = 1'b0;
   logic [15:0] td16 = 16'h0000;
   logic        rdy16, rv16, busy16, sclk16, mosi16, cs16;
   logic [15:0] rd16;

   spi_master_core #(.DATA_W(16), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0)) u16 (
      .clk(clk), .rst(rst16), .tx_valid(tv16), .tx_ready(rdy16), .tx_data(td16),
      .tx_last(tl16), .rx_valid(rv16), .rx_data(rd16), .busy(busy16),
      .spi_sclk(sclk16), .spi_mosi(mosi16), .spi_miso(miso16), .spi_cs_n(cs16));

   // ---------------- slave models ----------------
   // Mode 0 slaves: present a bit on CS fall / trailing (falling) edge,
   // and capture MOSI on rising edges. They reload every DATA_W bits, so a
   // burst frame sees a fresh word.
   logic [7:0] s0_tx = 8'h00, s0_sh = 8'h00, s0_cap = 8'h00;
   logic       cs0_prev = 1'b1, sclk0_prev = 1'b0;
   int         s0_bits = 0, s0_rise = 0, s0_falls = 0, s0_edges = 0;
   logic [7:0] q0[$];

   always @(cs0 or sclk0) begin
      if (cs0 !== cs0_prev) begin
         if (cs0 === 1'b0) begin
            s0_sh = s0_tx; miso0 = s0_sh[7]; s0_bits = 0; s0_rise = 0; s0_falls++;
         end
      end else if (cs0 === 1'b0 && sclk0 !== sclk0_prev) begin
         s0_edges++;
         if (sclk0 === 1'b1) begin
            s0_cap = {s0_cap[6:0], mosi0}; s0_rise++; s0_bits++;
            if (s0_bits == 8) begin q0.push_back(s0_cap); s0_bits = 0; end
         end else begin
            if (s0_bits == 0) s0_sh = s0_tx; else s0_sh = s0_sh << 1;
            miso0 = s0_sh[7];
         end
      end
      cs0_prev = cs0; sclk0_prev = sclk0;
   end

   // Mode 3 slave: present on leading (falling) edge, capture on rising edge.
   logic [7:0] s3_tx = 8'h00, s3_sh = 8'h00, s3_cap = 8'h00;
   logic       cs3_prev = 1'b1, sclk3_prev = 1'b1;
   int         s3_bits = 0, s3_rise = 0;
   logic [7:0] q3[$];

   always @(cs3 or sclk3) begin
      if (cs3 !== cs3_prev) begin
         if (cs3 === 1'b0) begin s3_sh = s3_tx; s3_bits = 0; s3_rise = 0; end
      end else if (cs3 === 1'b0 && sclk3 !== sclk3_prev) begin
         if (sclk3 === 1'b0) begin
            miso3 = s3_sh[7]; s3_sh = s3_sh << 1;
         end else begin
            s3_cap = {s3_cap[6:0], mosi3}; s3_rise++; s3_bits++;
            if (s3_bits == 8) begin q3.push_back(s3_cap); s3_bits = 0; end
         end
      end
      cs3_prev = cs3; sclk3_prev = sclk3;
   end

   logic [15:0] s16_tx = 16'h0000, s16_sh = 16'h0000, s16_cap = 16'h0000;
   logic        cs16_prev = 1'b1, sclk16_prev = 1'b0;
   int          s16_bits = 0;
   logic [15:0] q16[$];

   always @(cs16 or sclk16) begin
      if (cs16 !== cs16_prev) begin
         if (cs16 === 1'b0) begin s16_sh = s16_tx; miso16 = s16_sh[15]; s16_bits = 0; end
      end else if (cs16 === 1'b0 && sclk16 !== sclk16_prev) begin
         if (sclk16 === 1'b1) begin
            s16_cap = {s16_cap[14:0], mosi16}; s16_bits++;
            if (s16_bits == 16) begin q16.push_back(s16_cap); s16_bits = 0; end
         end else begin
            if (s16_bits == 0) s16_sh = s16_tx; else s16_sh = s16_sh << 1;
            miso16 = s16_sh[15];
         end
      end
      cs16_prev = cs16; sclk16_prev = sclk16;
   end

   // rx_valid pulse counter (counts cycles in which rx_valid was high)
   int rv0_cnt = 0;
   always @(posedge clk) if (rv0 === 1'b1) rv0_cnt++;

   // ---------------- helpers ----------------
   // Latency is the handshake-to-capture distance: rx_valid is seen after edge
   // hs+m, and a downstream register captures it on edge hs+m+1.
   task automatic xfer0(input logic [7:0] tx, input logic [7:0] sd, input int poke,
                        output int lat, output int ready_hi);
      int k;
      s0_tx = sd;
      k = 0;
      while (rdy0 !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
      tv0 = 1'b1; td0 = tx;
      @(posedge clk); #1;
      tv0 = 1'b0; td0 = 8'h00;
      lat = -1; ready_hi = 0;
      for (int j = 0; j < 200 && lat < 0; j++) begin
         if (j < poke) begin
            tv0 = 1'b1; td0 = 8'h00;
            if (rdy0 !== 1'b0) ready_hi++;
         end else begin
            tv0 = 1'b0;
         end
         @(posedge clk); #1;
         if (rv0 === 1'b1) lat = j + 2;
      end
      tv0 = 1'b0;
   endtask

   // Two words with tx_valid held high throughout. Reports cs_n-high cycles
   // between the words, frames started and rising edges in the last frame.
   task automatic pair0(input logic last_first, output int gap, output int frames,
                        output int rises, output int pulses);
      int hs_cnt, fb, rb, k;
      logic rv_seen, will_hs;
      fb = s0_falls; rb = rv0_cnt;
      s0_tx = 8'h44;
      gap = 0; hs_cnt = 0; rv_seen = 1'b0;
      k = 0;
      while (rdy0 !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
      tv0 = 1'b1; td0 = 8'h11; tl0 = last_first;
      for (int j = 0; j < 400 && (rv0_cnt - rb) < 2; j++) begin
         will_hs = tv0 & rdy0;
         @(posedge clk); #1;
         if (will_hs) begin
            hs_cnt++;
            if (hs_cnt == 1) begin td0 = 8'h22; tl0 = 1'b1; end
            else tv0 = 1'b0;
         end
         if (rv0 === 1'b1) rv_seen = 1'b1;
         if (rv_seen && hs_cnt == 1 && cs0 === 1'b1) gap++;
      end
      tv0 = 1'b0; tl0 = 1'b1;
      @(posedge clk); #1;
      frames = s0_falls - fb;
      rises  = s0_rise;
      pulses = rv0_cnt - rb;
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] sd;
      logic [7:0] exp_rx;
      logic [7:0] exp_mosi;
      int         exp_lat;
   } vec_t;

   vec_t vt[5];

   initial begin
      int lat, rh, base, rvb, k, gap, frames, rises, pulses;

      vt[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 73};
      vt[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 73};
      vt[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 73};
      vt[3] = '{8'h5A, 8'hA5, 8'hA5, 8'h5A, 73};
      vt[4] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 73};

      // Reset values
      #1 rst0 = 1'b1; rst3 = 1'b1; rst16 = 1'b1;
      #1;
      check("rst tx_ready",  32'(rdy0),  32'h0);
      check("rst rx_valid",  32'(rv0),   32'h0);
      check("rst rx_data",   32'(rd0),   32'h0);
      check("rst busy",      32'(busy0), 32'h0);
      check("rst sclk m0",   32'(sclk0), 32'h0);
      check("rst mosi",      32'(mosi0), 32'h0);
      check("rst cs_n",      32'(cs0),   32'h1);
      check("rst sclk m3",   32'(sclk3), 32'h1);
      repeat (2) @(posedge clk);
      #1 rst0 = 1'b0; rst3 = 1'b0; rst16 = 1'b0;
      #1;
      check("idle tx_ready", 32'(rdy0), 32'h1);
      check("idle busy m3",  32'(busy3), 32'h0);
      @(posedge clk); #1;

      // Table-driven mode 0 transfers
      for (int i = 0; i < 5; i++) begin
         base = q0.size();
         xfer0(vt[i].tx, vt[i].sd, 0, lat, rh);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
         check($sformatf("vec%0d rx_data", i), 32'(rd0), 32'(vt[i].exp_rx));
         check($sformatf("vec%0d mosi words", i), 32'(q0.size() - base), 32'd1);
         if (q0.size() > base)
            check($sformatf("vec%0d mosi", i), 32'(q0[base]), 32'(vt[i].exp_mosi));
         check($sformatf("vec%0d sclk rises", i), 32'(s0_rise), 32'd8);
         check($sformatf("vec%0d sclk end", i), 32'(sclk0), 32'h0);
         @(posedge clk); #1;
         check($sformatf("vec%0d rx_valid 1cyc", i), 32'(rv0), 32'h0);
         check($sformatf("vec%0d cs_n idle", i), 32'(cs0), 32'h1);
      end

      // Mode 3: send 0x81, slave returns 0x7E
      s3_tx = 8'h7E;
      base = q3.size();
      k = 0;
      while (rdy3 !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
      tv3 = 1'b1; td3 = 8'h81;
      @(posedge clk); #1;
      tv3 = 1'b0;
      check("m3 busy", 32'(busy3), 32'h1);
      lat = -1;
      for (int j = 0; j < 200 && lat < 0; j++) begin
         @(posedge clk); #1;
         if (rv3 === 1'b1) lat = j + 2;
      end
      check("m3 latency", 32'(lat), 32'd73);
      check("m3 rx_data", 32'(rd3), 32'h7E);
      check("m3 mosi words", 32'(q3.size() - base), 32'd1);
      if (q3.size() > base) check("m3 mosi", 32'(q3[base]), 32'h81);
      check("m3 rises", 32'(s3_rise), 32'd8);
      check("m3 sclk end", 32'(sclk3), 32'h1);

      // DATA_W=16, CLK_DIV=1: send 0xBEEF, slave returns 0x1234
      s16_tx = 16'h1234;
      base = q16.size();
      k = 0;
      while (rdy16 !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
      tv16 = 1'b1; td16 = 16'hBEEF;
      @(posedge clk); #1;
      tv16 = 1'b0;
      lat = -1;
      for (int j = 0; j < 200 && lat < 0; j++) begin
         @(posedge clk); #1;
         if (rv16 === 1'b1) lat = j + 2;
      end
      check("w16 latency", 32'(lat), 32'd35);
      check("w16 rx_data", 32'(rd16), 32'h1234);
      if (q16.size() > base) check("w16 mosi", 32'(q16[base]), 32'hBEEF);
      else check("w16 mosi words", 32'(q16.size() - base), 32'd1);
      @(posedge clk); #1;
      check("w16 busy end", 32'(busy16), 32'h0);

      // Abort: reset after the 5th SCLK edge of 0xFF
      s0_tx = 8'h99;
      k = s0_edges;
      tv0 = 1'b1; td0 = 8'hFF;
      @(posedge clk); #1;
      tv0 = 1'b0;
      check("abort busy", 32'(busy0), 32'h1);
      rh = 0;
      while ((s0_edges - k) < 5 && rh < 200) begin @(posedge clk); #1; rh++; end
      check("abort reached 5 edges", 32'(s0_edges - k), 32'd5);
      rvb = rv0_cnt;
      #2 rst0 = 1'b1;
      #1;
      check("abort cs_n", 32'(cs0), 32'h1);
      check("abort sclk", 32'(sclk0), 32'h0);
      check("abort rx_data", 32'(rd0), 32'h0);
      check("abort tx_ready", 32'(rdy0), 32'h0);
      @(posedge clk); #1;
      rst0 = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      check("abort no rx_valid", 32'(rv0_cnt - rvb), 32'd0);
      base = q0.size();
      xfer0(8'h5A, 8'hC5, 0, lat, rh);
      check("post-abort latency", 32'(lat), 32'd73);
      check("post-abort rx_data", 32'(rd0), 32'hC5);
      if (q0.size() > base) check("post-abort mosi", 32'(q0[base]), 32'h5A);
      else check("post-abort mosi words", 32'(q0.size() - base), 32'd1);

      // tx_valid with 0x00 while busy with 0xC3
      repeat (2) @(posedge clk);
      #1;
      rvb = rv0_cnt;
      base = q0.size();
      xfer0(8'hC3, 8'h96, 40, lat, rh);
      repeat (3) @(posedge clk);
      #1;
      check("busy-poke tx_ready", 32'(rh), 32'd0);
      check("busy-poke latency", 32'(lat), 32'd73);
      check("busy-poke rx_data", 32'(rd0), 32'h96);
      check("busy-poke mosi words", 32'(q0.size() - base), 32'd1);
      if (q0.size() > base) check("busy-poke mosi", 32'(q0[base]), 32'hC3);
      check("busy-poke rx pulses", 32'(rv0_cnt - rvb), 32'd1);

      // Back-to-back with tx_last=1: always two separate frames
      base = q0.size();
      pair0(1'b1, gap, frames, rises, pulses);
      check("b2b frames", 32'(frames), 32'd2);
      check("b2b cs_n gap>=1", 32'(gap >= 1), 32'h1);
      check("b2b rx pulses", 32'(pulses), 32'd2);
      check("b2b rx_data", 32'(rd0), 32'h44);
      if (q0.size() >= base + 2) begin
         check("b2b mosi0", 32'(q0[base]), 32'h11);
         check("b2b mosi1", 32'(q0[base+1]), 32'h22);
      end else check("b2b mosi words", 32'(q0.size() - base), 32'd2);

      // First word with tx_last=0: burst when the feature is built in
      base = q0.size();
      pair0(1'b0, gap, frames, rises, pulses);
      check("tl0 rx pulses", 32'(pulses), 32'd2);
`ifdef SPI_MASTER_BURST_EN
      check("burst frames", 32'(frames), 32'd1);
      check("burst rises", 32'(rises), 32'd16);
      check("burst cs_n gap", 32'(gap), 32'd0);
`else
      check("tl0 frames", 32'(frames), 32'd2);
      check("tl0 rises", 32'(rises), 32'd8);
      check("tl0 cs_n gap>=1", 32'(gap >= 1), 32'h1);
`endif
      if (q0.size() >= base + 2) begin
         check("tl0 mosi0", 32'(q0[base]), 32'h11);
         check("tl0 mosi1", 32'(q0[base+1]), 32'h22);
      end else check("tl0 mosi words", 32'(q0.size() - base), 32'd2);
      check("tl0 rx_data", 32'(rd0), 32'h44);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
